ramp_checker: RTL and testbench
===============================

// Module: ramp_checker
// PURPOSE
//  Receive-side checker for the free-running ramp stream (32-bit count, wrap pulse).
//  Qualifies DataIn on trig strobes and predicts the next value:
//    - after Ref_CNT the ramp wraps to 0;
//    - otherwise it increments, mod 2^32.
//  Hunts and locks onto the stream, counts discontinuities, checks the wrap marker
//  and measures the ramp period. Sits at the far end of the data path for link and
//  loopback integrity tests.
// PARAMETERS
//  DATA_W    32  ramp sample width
//  LOCK_CNT  4   consecutive matching samples required to enter LOCKED (>=2)
//  ERR_W     16  width of saturating error counter
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  reset        in   1       synchronous, active-high
//  trig         in   1       sample-valid strobe; DataIn/RstIn ignored when low
//  Ref_CNT      in   DATA_W  terminal count of the ramp (same value as generator)
//  DataIn       in   DATA_W  received ramp sample
//  RstIn        in   1       received wrap marker, must be 1 iff DataIn==Ref_CNT
//  locked       out  1       1 while in LOCKED
//  err_pulse    out  1       one-cycle pulse per detected error while LOCKED
//  err_cnt      out  ERR_W   errors since reset, saturates at all-ones
//  wrap_cnt     out  DATA_W  completed periods (DataIn==0 seen while LOCKED), wraps
//  period_meas  out  DATA_W  valid samples between last two zeros while LOCKED
// BEHAVIOUR
//  - Sync reset values:
//    - state=HUNT; all outputs 0;
//    - exp=0, good=0, per_cnt=0, per_valid=0.
//  - All outputs registered; response appears 1 clk after the trig cycle.
//  - nxt(s) = (s==Ref_CNT) ? 0 : s+1 (32-bit wrap, so FFFFFFFF->0 always).
//  - Ref_CNT is sampled live each trig cycle; a change mid-run acts on the next compare.
//  - match = (DataIn==exp) && (RstIn==(DataIn==Ref_CNT)).
//  - Every trig cycle sets exp<=nxt(DataIn), in all states.
//  - States:
//    - HUNT: on trig -> TRACK, good<=1.
//    - TRACK, trig:
//      - match: good<=good+1; when good==LOCK_CNT-1 -> LOCKED, per_valid<=0.
//      - mismatch: good<=1, stay in TRACK, no error counted.
//    - LOCKED, trig:
//      - mismatch: err_pulse<=1; err_cnt++ (saturating); -> TRACK, good<=1, locked<=0.
//      - match with DataIn==0:
//        - if per_valid: period_meas<=per_cnt, wrap_cnt<=wrap_cnt+1;
//        - per_cnt<=1, per_valid<=1.
//      - match with DataIn!=0: per_cnt<=per_cnt+1.
//  - trig low: no state, count or exp change; err_pulse deasserts.
//  - First zero after lock only arms the period measurement, so no partial period is
//    ever reported. period_meas holds its last value through loss of lock.
//  - Ref_CNT=0: stream of zeros is valid; period_meas=1 and RstIn must stay 1.
//  - err_cnt at all-ones stays there, but err_pulse still fires.
//  - reset asserted mid-stream: next cycle equals the post-reset state regardless of trig.
// STRUCTURE
//  - Package ramp_pkg:
//    - state enum {HUNT,TRACK,LOCKED};
//    - DATA_W default;
//    - function ramp_nxt(s, ref), shared with the generator model in the bench.
//  - One sub-module: ramp_sat_cnt (WIDTH param; inc, clr; saturating), used for err_cnt.
//  - Rest is one FSM process plus datapath registers.
// TESTING
//  - Clean ramp, Ref_CNT=9, trig every cycle from 0:
//    - locked=1 after 4th sample;
//    - period_meas=10, wrap_cnt increments every 10 samples; err_cnt=0.
//  - Locked, skip value 5 (4 then 6):
//    - err_pulse one cycle, err_cnt=1, locked drops;
//    - relock after 6,7,8,9 (LOCK_CNT=4).
//  - Locked, RstIn forced 0 at DataIn==Ref_CNT:
//    - err_cnt+1, state TRACK, period_meas unchanged.
//  - Ref_CNT=0, DataIn=0, RstIn=1 on every trig:
//    - locks; period_meas=1, wrap_cnt counts every sample after arm.
//  - ERR_W=2, inject 5 errors: err_cnt=3 held, 5 err_pulses seen.
//  - Sparse trig (1 of 3 cycles): identical results to the dense case.
//  - Reset mid-LOCKED: all outputs 0 next cycle, state HUNT.
//  - DataIn=FFFFFFFE, FFFFFFFF, 0 with Ref_CNT=FFFFFFFF: no error.

Source files
------------

// File: rtl/ramp_pkg.sv
// Shared types and the ramp successor function, used by the checker and by the
// generator model in the bench so both agree on how the stream advances.
package ramp_pkg;

    localparam int unsigned RAMP_DATA_W = 32;

    typedef enum logic [1:0] {
        StHunt,
        StTrack,
        StLocked
    } ramp_state_e;

    // Wraps to zero after the terminal count; plain increment also wraps at 2^W.
    function automatic logic [RAMP_DATA_W-1:0] ramp_nxt(
        input logic [RAMP_DATA_W-1:0] s,
        input logic [RAMP_DATA_W-1:0] ref_cnt
    );
        return (s == ref_cnt) ? '0 : s + RAMP_DATA_W'(1);
    endfunction

endpackage

// File: rtl/ramp_sat_cnt.sv
// Saturating up-counter: holds at all-ones once reached; clear has priority.
module ramp_sat_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ramp_checker.sv
// Receive-side ramp checker: hunts/locks onto the ramp stream, counts discontinuities
// while locked, verifies the wrap marker and measures the ramp period.
module ramp_checker
    import ramp_pkg::*;
#(
    parameter int unsigned DATA_W   = RAMP_DATA_W,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trig,
    input  logic [DATA_W-1:0] Ref_CNT,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              RstIn,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] wrap_cnt,
    output logic [DATA_W-1:0] period_meas
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);

    ramp_state_e       state_q;
    logic [DATA_W-1:0] exp_q;
    logic [GOOD_W-1:0] good_q;
    logic [DATA_W-1:0] per_cnt_q;
    logic              per_valid_q;
    logic              locked_q;
    logic              err_pulse_q;
    logic [DATA_W-1:0] wrap_cnt_q;
    logic [DATA_W-1:0] period_meas_q;

    logic is_ref;
    logic match;
    logic err_inc;

    // The wrap marker must be high exactly on the terminal count, never elsewhere.
    assign is_ref  = (DataIn == Ref_CNT);
    assign match   = (DataIn == exp_q) && (RstIn == is_ref);
    assign err_inc = trig && (state_q == StLocked) && !match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StHunt;
            exp_q         <= '0;
            good_q        <= '0;
            per_cnt_q     <= '0;
            per_valid_q   <= 1'b0;
            locked_q      <= 1'b0;
            err_pulse_q   <= 1'b0;
            wrap_cnt_q    <= '0;
            period_meas_q <= '0;
        end else begin
            err_pulse_q <= 1'b0;
            if (trig) begin
                exp_q <= ramp_nxt(DataIn, Ref_CNT);
                unique case (state_q)
                    StHunt: begin
                        state_q <= StTrack;
                        good_q  <= GOOD_W'(1);
                    end
                    StTrack: begin
                        if (match) begin
                            good_q <= good_q + GOOD_W'(1);
                            if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                                state_q     <= StLocked;
                                locked_q    <= 1'b1;
                                per_valid_q <= 1'b0;
                            end
                        end else begin
                            good_q <= GOOD_W'(1);
                        end
                    end
                    StLocked: begin
                        if (!match) begin
                            err_pulse_q <= 1'b1;
                            state_q     <= StTrack;
                            good_q      <= GOOD_W'(1);
                            locked_q    <= 1'b0;
                        end else if (DataIn == '0) begin
                            // First zero after lock only arms, so no partial period leaks out.
                            if (per_valid_q) begin
                                period_meas_q <= per_cnt_q;
                                wrap_cnt_q    <= wrap_cnt_q + DATA_W'(1);
                            end
                            per_cnt_q   <= DATA_W'(1);
                            per_valid_q <= 1'b1;
                        end else begin
                            per_cnt_q <= per_cnt_q + DATA_W'(1);
                        end
                    end
                    default: begin
                        state_q <= StHunt;
                    end
                endcase
            end
        end
    end

    ramp_sat_cnt #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .clr_i(reset),
        .inc_i(err_inc),
        .cnt_o(err_cnt)
    );

    assign locked      = locked_q;
    assign err_pulse   = err_pulse_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign period_meas = period_meas_q;

endmodule

// File: tb/tb_ramp_checker.sv
// Bench for ramp_checker: hand-derived vector table plus model-driven ramp scenarios,
// all expectations queued at drive time and compared one clock later.
module tb_ramp_checker;
    import ramp_pkg::*;

    localparam int unsigned DW   = 32;
    localparam int unsigned LOCK = 4;

    typedef struct {
        bit          locked;
        bit          ep;
        int unsigned err;
        logic [31:0] wrap;
        logic [31:0] period;
    } exp_t;

    typedef struct {
        bit          trig;
        logic [31:0] data;
        bit          rst;
        exp_t        e;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          trig = 1'b0;
    logic          rst_in = 1'b0;
    logic [DW-1:0] ref_cnt = '0;
    logic [DW-1:0] data_in = '0;
    logic          locked, err_pulse, locked2, err_pulse2;
    logic [15:0]   err_cnt;
    logic [1:0]    err_cnt2;
    logic [DW-1:0] wrap_cnt, period_meas, wrap_cnt2, period_meas2;

    int   checks = 0;
    int   errors = 0;
    int   pulses2 = 0;
    exp_t sb_q[$];
    vec_t tbl[$];
    logic [31:0] cur;

    // Generator-side model state
    int          m_st, m_good;
    logic [31:0] m_exp, m_per_cnt, m_wrap, m_period;
    bit          m_per_valid, m_locked, m_ep;
    int unsigned m_err;

    always #5 clk = ~clk;

    ramp_checker #(.DATA_W(DW), .LOCK_CNT(LOCK), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .trig(trig), .Ref_CNT(ref_cnt), .DataIn(data_in),
        .RstIn(rst_in), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt),
        .wrap_cnt(wrap_cnt), .period_meas(period_meas)
    );

    ramp_checker #(.DATA_W(DW), .LOCK_CNT(LOCK), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .trig(trig), .Ref_CNT(ref_cnt), .DataIn(data_in),
        .RstIn(rst_in), .locked(locked2), .err_pulse(err_pulse2), .err_cnt(err_cnt2),
        .wrap_cnt(wrap_cnt2), .period_meas(period_meas2)
    );

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", tag);
            return;
        end
        e = sb_q.pop_front();
        if (err_pulse2 === 1'b1) pulses2++;
        chk({tag, ".locked"}, 64'(locked), 64'(e.locked));
        chk({tag, ".err_pulse"}, 64'(err_pulse), 64'(e.ep));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'((e.err > 65535) ? 65535 : e.err));
        chk({tag, ".err_cnt2"}, 64'(err_cnt2), 64'((e.err > 3) ? 3 : e.err));
        chk({tag, ".err_pulse2"}, 64'(err_pulse2), 64'(e.ep));
        chk({tag, ".wrap_cnt"}, 64'(wrap_cnt), 64'(e.wrap));
        chk({tag, ".period_meas"}, 64'(period_meas), 64'(e.period));
    endtask

    task automatic apply(input bit t, input logic [31:0] r, input logic [31:0] d,
                         input bit ri, input exp_t e, input string tag);
        trig    = t;
        ref_cnt = r;
        data_in = d;
        rst_in  = ri;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic model_reset();
        m_st = 0; m_good = 0; m_exp = '0; m_per_cnt = '0; m_per_valid = 0;
        m_locked = 0; m_ep = 0; m_err = 0; m_wrap = '0; m_period = '0;
    endtask

    task automatic model_step(input bit t, input logic [31:0] r, input logic [31:0] d,
                              input bit ri);
        bit mt;
        m_ep = 0;
        if (!t) return;
        mt = (d == m_exp) && (ri == (d == r));
        m_exp = ramp_nxt(d, r);
        if (m_st == 0) begin
            m_st = 1;
            m_good = 1;
        end else if (m_st == 1) begin
            if (!mt) m_good = 1;
            else if (m_good == LOCK - 1) begin
                m_st = 2; m_locked = 1; m_per_valid = 0; m_good++;
            end else m_good++;
        end else if (!mt) begin
            m_ep = 1; m_err++; m_st = 1; m_good = 1; m_locked = 0;
        end else if (d == 0) begin
            if (m_per_valid) begin
                m_period = m_per_cnt;
                m_wrap++;
            end
            m_per_cnt = 1;
            m_per_valid = 1;
        end else m_per_cnt++;
    endtask

    task automatic drive(input bit t, input logic [31:0] r, input logic [31:0] d,
                         input bit ri, input string tag);
        exp_t e;
        model_step(t, r, d, ri);
        e.locked = m_locked; e.ep = m_ep; e.err = m_err;
        e.wrap = m_wrap; e.period = m_period;
        apply(t, r, d, ri, e, tag);
    endtask

    task automatic do_reset(input bit t, input string tag);
        exp_t e;
        e.locked = 0; e.ep = 0; e.err = 0; e.wrap = '0; e.period = '0;
        model_reset();
        reset = 1'b1;
        apply(t, ref_cnt, $urandom, bit'($urandom_range(0, 1)), e, tag);
        reset = 1'b0;
    endtask

    // Feeds n ramp samples from cur, with gap idle (trig low) cycles before each.
    task automatic run_ramp(input logic [31:0] r, input int n, input int gap,
                            input string tag);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                drive(0, r, $urandom, bit'($urandom_range(0, 1)), {tag, "_idle"});
            end
            drive(1, r, cur, cur == r, tag);
            cur = ramp_nxt(cur, r);
        end
    endtask

    task automatic add(input bit t, input logic [31:0] d, input bit ri, input bit lk,
                       input bit ep, input int unsigned er, input logic [31:0] wr,
                       input logic [31:0] pr);
        vec_t v;
        v.trig = t; v.data = d; v.rst = ri;
        v.e.locked = lk; v.e.ep = ep; v.e.err = er; v.e.wrap = wr; v.e.period = pr;
        tbl.push_back(v);
    endtask

    initial begin
        // Ref_CNT=2 stream: lock, two periods of 3, a skip error, relock.
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0);
        add(1, 2, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0, 0, 0);
        add(1, 2, 1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 0, 0, 1, 3);
        add(0, 7, 1, 1, 0, 0, 1, 3);
        add(1, 1, 0, 1, 0, 0, 1, 3);
        add(1, 2, 1, 1, 0, 0, 1, 3);
        add(1, 0, 0, 1, 0, 0, 2, 3);
        add(1, 2, 1, 0, 1, 1, 2, 3);
        add(0, 0, 0, 0, 0, 1, 2, 3);
        add(1, 0, 0, 0, 0, 1, 2, 3);
        add(1, 1, 1, 0, 0, 1, 2, 3);
        add(1, 2, 1, 0, 0, 1, 2, 3);
        add(1, 0, 0, 0, 0, 1, 2, 3);
        add(1, 1, 0, 1, 0, 1, 2, 3);

        do_reset(0, "reset_init");
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].trig, 32'd2, tbl[i].data, tbl[i].rst, tbl[i].e,
                  $sformatf("tbl[%0d]", i));
        end

        // Clean ramp Ref_CNT=9, dense then sparse (1 of 3 cycles)
        for (int gap = 0; gap <= 2; gap += 2) begin
            do_reset(0, "reset_a");
            cur = '0;
            run_ramp(9, 3, gap, "ramp9");
            chk("ramp9_locked_after_3", 64'(locked), 64'd0);
            run_ramp(9, 1, gap, "ramp9");
            chk("ramp9_locked_after_4", 64'(locked), 64'd1);
            run_ramp(9, 31, gap, "ramp9");
            chk("ramp9_wrap", 64'(wrap_cnt), 64'd2);
            chk("ramp9_period", 64'(period_meas), 64'd10);
            chk("ramp9_err", 64'(err_cnt), 64'd0);
        end

        // Skip value 5: error, then relock on 6,7,8,9
        cur = ramp_nxt(cur, 9);
        drive(1, 9, cur, cur == 9, "skip");
        cur = ramp_nxt(cur, 9);
        chk("skip_pulse", 64'(err_pulse), 64'd1);
        chk("skip_err", 64'(err_cnt), 64'd1);
        chk("skip_unlocked", 64'(locked), 64'd0);
        run_ramp(9, 1, 0, "relock");
        chk("skip_pulse_drop", 64'(err_pulse), 64'd0);
        run_ramp(9, 1, 0, "relock");
        chk("relock_not_yet", 64'(locked), 64'd0);
        run_ramp(9, 1, 0, "relock");
        chk("relock_done", 64'(locked), 64'd1);

        // Wrap marker dropped at the terminal count
        run_ramp(9, 9, 0, "pre_mark");
        drive(1, 9, 32'd9, 0, "bad_mark");
        cur = '0;
        chk("bad_mark_err", 64'(err_cnt), 64'd2);
        chk("bad_mark_unlocked", 64'(locked), 64'd0);
        chk("bad_mark_period", 64'(period_meas), 64'd10);

        // Five errors: 16-bit counter reaches 5, 2-bit counter saturates at 3
        do_reset(0, "reset_d");
        cur = '0;
        pulses2 = 0;
        run_ramp(9, 4, 0, "sat_lock");
        for (int k = 0; k < 5; k++) begin
            cur = ramp_nxt(cur, 9);
            drive(1, 9, cur, cur == 9, "sat_err");
            cur = ramp_nxt(cur, 9);
            run_ramp(9, 3, 0, "sat_relock");
        end
        chk("sat_err_cnt", 64'(err_cnt), 64'd5);
        chk("sat_err_cnt2", 64'(err_cnt2), 64'd3);
        chk("sat_pulses2", 64'(pulses2), 64'd5);

        // Ref_CNT=0: all-zero stream is a valid ramp of period 1
        do_reset(0, "reset_e");
        cur = '0;
        run_ramp(0, 12, 0, "zeros");
        chk("zeros_period", 64'(period_meas), 64'd1);
        chk("zeros_wrap", 64'(wrap_cnt), 64'd7);
        chk("zeros_locked", 64'(locked), 64'd1);

        // Reset while locked with trig high
        do_reset(1, "reset_mid");
        chk("reset_mid_locked", 64'(locked), 64'd0);
        chk("reset_mid_wrap", 64'(wrap_cnt), 64'd0);
        chk("reset_mid_err", 64'(err_cnt), 64'd0);

        // 32-bit terminal count wraps cleanly
        cur = 32'hFFFF_FFFC;
        run_ramp(32'hFFFF_FFFF, 6, 0, "top");
        chk("top_err", 64'(err_cnt), 64'd0);
        chk("top_locked", 64'(locked), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
